// File: rtl/mem_port_arbiter.sv
// Shares a single memory port between an instruction-fetch requester and a data requester.
// Data normally wins arbitration; a waiting fetch wins after STARVE_MAX consecutive data grants.
module mem_port_arbiter #(
  parameter int TIMEOUT    = 16,
  parameter int STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [8:0]  if_addr,
  output logic        if_done,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        d_req,
  input  logic        d_rw,
  input  logic [8:0]  d_addr,
  input  logic [5:0]  d_opc,
  input  logic [31:0] d_wdata,
  output logic        d_done,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        MOV,
  output logic        RW,
  output logic [8:0]  MAR,
  output logic [5:0]  OpC,
  output logic [31:0] DataIn,
  input  logic        MOC,
  input  logic [31:0] DataOut
);

  localparam int              SW           = $clog2(STARVE_MAX + 2);
  localparam logic [SW-1:0]   STARVE_LIMIT = SW'(STARVE_MAX);
  localparam logic [4:0]      TIMEOUT_LAST = 5'(TIMEOUT - 1);
  localparam logic [5:0]      OPC_WORD     = 6'b100011;

  typedef enum logic [1:0] {IDLE, ACCESS, RELEASE} state_t;

  state_t        state, state_next;
  logic          grant_fetch;
  logic [4:0]    access_cnt;
  logic [SW-1:0] starve_cnt;
  logic          any_req, pick_fetch, timeout;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    any_req    = if_req | d_req;
    pick_fetch = if_req & (~d_req | (starve_cnt == STARVE_LIMIT));
    timeout    = ~MOC & (access_cnt == TIMEOUT_LAST);
    state_next = state;
    case (state)
      IDLE:    if (any_req) state_next = ACCESS;
      ACCESS:  if (MOC || timeout) state_next = RELEASE;
      RELEASE: if (!MOC) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Memory-side signals are registered at the grant and held untouched until completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      MOV         <= 1'b0;
      RW          <= 1'b1;
      MAR         <= '0;
      OpC         <= '0;
      DataIn      <= '0;
      if_done     <= 1'b0;
      d_done      <= 1'b0;
      if_err      <= 1'b0;
      d_err       <= 1'b0;
      if_rdata    <= '0;
      d_rdata     <= '0;
      grant_fetch <= 1'b0;
      access_cnt  <= '0;
      starve_cnt  <= '0;
    end else begin
      if_done <= 1'b0;
      d_done  <= 1'b0;
      if_err  <= 1'b0;
      d_err   <= 1'b0;
      case (state)
        IDLE: begin
          access_cnt <= '0;
          if (!if_req) starve_cnt <= '0;
          if (any_req) begin
            MOV         <= 1'b1;
            grant_fetch <= pick_fetch;
            if (pick_fetch) begin
              RW         <= 1'b1;
              MAR        <= if_addr;
              OpC        <= OPC_WORD;
              DataIn     <= '0;
              starve_cnt <= '0;
            end else begin
              RW     <= d_rw;
              MAR    <= d_addr;
              OpC    <= d_opc;
              DataIn <= d_wdata;
              if (if_req && starve_cnt != STARVE_LIMIT) starve_cnt <= starve_cnt + 1'b1;
            end
          end
        end
        ACCESS: begin
          if (MOC) begin
            MOV <= 1'b0;
            if (grant_fetch) begin
              if_done  <= 1'b1;
              if_rdata <= DataOut;
            end else begin
              d_done <= 1'b1;
              if (RW) d_rdata <= DataOut;
            end
          end else if (timeout) begin
            MOV <= 1'b0;
            if (grant_fetch) if_err <= 1'b1;
            else             d_err  <= 1'b1;
          end else begin
            access_cnt <= access_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
